// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: DIFF = A - B - BORROW_IN over WIDTH bits, DIGIT bits per clock.
// START/DONE handshake; results and flags are registered and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BORROW_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             borrow, borrow_next;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig;
  logic             last;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    {borrow_next, dig} = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]}
                         - (DIGIT+1)'(borrow);
    // Result digits enter from the MSB side so the final digit lands on top.
    res_next = (res_sr >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
    last     = (cnt == CW'(N - 1));
    case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  assign BUSY = (state == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      DONE       <= 1'b0;
      DIFF       <= '0;
      BORROW_OUT <= 1'b0;
      OVERFLOW   <= 1'b0;
      ZERO       <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= BORROW_IN;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            res_sr <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            DONE       <= 1'b1;
            DIFF       <= res_next;
            BORROW_OUT <= borrow_next;
            OVERFLOW   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            ZERO       <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and reference-model checks of serial_subtractor in three configurations:
// 8/1, 8/4 and 16/2.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st8, bi8, bu8, dn8, bo8, ov8, z8;
  logic [7:0] a8, b8, d8;
  logic       st84, bi84, bu84, dn84, bo84, ov84, z84;
  logic [7:0] a84, b84, d84;
  logic        st16, bi16, bu16, dn16, bo16, ov16, z16;
  logic [15:0] a16, b16, d16;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .CLK(clk), .RST(rst), .START(st8), .A(a8), .B(b8), .BORROW_IN(bi8),
    .BUSY(bu8), .DONE(dn8), .DIFF(d8), .BORROW_OUT(bo8), .OVERFLOW(ov8), .ZERO(z8));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut84 (
    .CLK(clk), .RST(rst), .START(st84), .A(a84), .B(b84), .BORROW_IN(bi84),
    .BUSY(bu84), .DONE(dn84), .DIFF(d84), .BORROW_OUT(bo84), .OVERFLOW(ov84), .ZERO(z84));

  serial_subtractor #(.WIDTH(16), .DIGIT(2)) dut16 (
    .CLK(clk), .RST(rst), .START(st16), .A(a16), .B(b16), .BORROW_IN(bi16),
    .BUSY(bu16), .DONE(dn16), .DIFF(d16), .BORROW_OUT(bo16), .OVERFLOW(ov16), .ZERO(z16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer arithmetic, not the per-digit borrow chain.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic ov, output logic z);
    longint ua, ub, r, sa, sb, sr, m;
    m  = (64'sd1 << w);
    ua = longint'(a);
    ub = longint'(b);
    r  = ua - ub - longint'(bin);
    bo = (r < 0);
    d  = 16'((r + m) % m);
    sa = a[w-1] ? ua - m : ua;
    sb = b[w-1] ? ub - m : ub;
    sr = sa - sb - longint'(bin);
    ov = (sr < -(m / 2)) || (sr >= (m / 2));
    z  = (d == 16'h0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] e_d, input logic e_bo, input logic e_ov, input logic e_z);
    int cyc;
    a8 = a; b8 = b; bi8 = bin; st8 = 1'b1;
    tick();
    st8 = 1'b0; a8 = ~a; b8 = ~b; bi8 = ~bin;
    check({tag, " busy_after_accept"}, 32'(bu8), 32'd1);
    cyc = 0;
    while (!dn8 && cyc < 40) begin tick(); cyc++; end
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " diff"}, 32'(d8), 32'(e_d));
    check({tag, " borrow_out"}, 32'(bo8), 32'(e_bo));
    check({tag, " overflow"}, 32'(ov8), 32'(e_ov));
    check({tag, " zero"}, 32'(z8), 32'(e_z));
    check({tag, " busy_at_done"}, 32'(bu8), 32'd0);
    tick();
    check({tag, " done_one_cycle"}, 32'(dn8), 32'd0);
  endtask

  task automatic op84(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] e_d, input logic e_bo, input logic e_ov);
    int cyc;
    a84 = a; b84 = b; bi84 = bin; st84 = 1'b1;
    tick();
    st84 = 1'b0;
    cyc = 0;
    while (!dn84 && cyc < 40) begin tick(); cyc++; end
    check({tag, " latency"}, 32'(cyc), 32'd2);
    check({tag, " diff"}, 32'(d84), 32'(e_d));
    check({tag, " borrow_out"}, 32'(bo84), 32'(e_bo));
    check({tag, " overflow"}, 32'(ov84), 32'(e_ov));
    tick();
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] e_d, input logic e_bo, input logic e_ov, input logic e_z);
    int cyc;
    a16 = a; b16 = b; bi16 = bin; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    cyc = 0;
    while (!dn16 && cyc < 40) begin tick(); cyc++; end
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " diff"}, 32'(d16), 32'(e_d));
    check({tag, " borrow_out"}, 32'(bo16), 32'(e_bo));
    check({tag, " overflow"}, 32'(ov16), 32'(e_ov));
    check({tag, " zero"}, 32'(z16), 32'(e_z));
    tick();
  endtask

  initial begin
    logic [15:0] ra, rb, md;
    logic        rbin, mbo, mov, mz;
    int          cyc, dones;

    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    st84 = 0; a84 = 0; b84 = 0; bi84 = 0;
    st16 = 0; a16 = 0; b16 = 0; bi16 = 0;
    tick(); tick();
    check("reset busy", 32'(bu8), 32'd0);
    check("reset done", 32'(dn8), 32'd0);
    check("reset diff", 32'(d8), 32'd0);
    check("reset borrow_out", 32'(bo8), 32'd0);
    check("reset overflow", 32'(ov8), 32'd0);
    check("reset zero", 32'(z8), 32'd1);
    rst = 1'b0;
    tick();

    // Basic cases, 8/1
    op8("c02_01", 8'h02, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    op8("c0f_01", 8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0);
    op8("c00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    op8("caa_55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
    op8("cf0_0f", 8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0);
    // Flags and borrow-in
    op8("c80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8("c05_05", 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    op8("c05_04_bi", 8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    op8("c00_00_bi", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // START re-pulsed during RUN is ignored
    a8 = 8'hAA; b8 = 8'h55; bi8 = 1'b0; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    cyc = 0;
    repeat (3) begin tick(); cyc++; end
    a8 = 8'h11; b8 = 8'h01; st8 = 1'b1;
    tick(); cyc++;
    st8 = 1'b0;
    while (!dn8 && cyc < 40) begin tick(); cyc++; end
    check("restart latency", 32'(cyc), 32'd8);
    check("restart diff", 32'(d8), 32'h55);
    dones = 0;
    repeat (12) begin tick(); if (dn8) dones++; end
    check("restart no_second_done", 32'(dones), 32'd0);

    // START held high: one result every N+1 cycles
    a8 = 8'h03; b8 = 8'h01; bi8 = 1'b0; st8 = 1'b1;
    tick();
    cyc = 0;
    while (!dn8 && cyc < 40) begin tick(); cyc++; end
    check("held first latency", 32'(cyc), 32'd8);
    repeat (2) begin
      cyc = 0;
      tick(); cyc++;
      while (!dn8 && cyc < 40) begin tick(); cyc++; end
      check("held done period", 32'(cyc), 32'd9);
      check("held diff", 32'(d8), 32'h02);
    end
    st8 = 1'b0;
    repeat (2) tick();
    check("held stops busy", 32'(bu8), 32'd0);

    // Reset mid-operation after a prior result of 0x55
    op8("pre_rst", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
    a8 = 8'h10; b8 = 8'h01; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", 32'(bu8), 32'd0);
    check("midrst diff", 32'(d8), 32'h00);
    check("midrst zero", 32'(z8), 32'd1);
    check("midrst overflow", 32'(ov8), 32'd0);
    check("midrst done", 32'(dn8), 32'd0);
    dones = 0;
    repeat (12) begin tick(); if (dn8) dones++; end
    check("midrst no_done", 32'(dones), 32'd0);
    op8("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    // Other configurations
    op84("w8d4_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op16("w16d2_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b1, 1'b0, 1'b0);

    // Randomised against the integer reference model
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom) & 16'h00FF; rb = 16'($urandom) & 16'h00FF; rbin = 1'($urandom);
      model(8, ra, rb, rbin, md, mbo, mov, mz);
      op8("rand8x1", ra[7:0], rb[7:0], rbin, md[7:0], mbo, mov, mz);
      ra = 16'($urandom) & 16'h00FF; rb = 16'($urandom) & 16'h00FF; rbin = 1'($urandom);
      model(8, ra, rb, rbin, md, mbo, mov, mz);
      op84("rand8x4", ra[7:0], rb[7:0], rbin, md[7:0], mbo, mov);
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      model(16, ra, rb, rbin, md, mbo, mov, mz);
      op16("rand16x2", ra, rb, rbin, md, mbo, mov, mz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
